// File: rtl/pipelined_barrel_shifter.sv
// Pipelined LSR/ASR/LSL/ROR barrel shifter: one register per log2 stage, valid/ready with full-pipe stall.
// Define BSH_STICKY_EN to build the sticky (discarded-bit OR) path; otherwise out_sticky is tied to 0.
module pipelined_barrel_shifter #(
   parameter int unsigned WIDTH   = 11,
   parameter int unsigned SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_sticky
);

   localparam logic [1:0] MODE_LSR = 2'b00;
   localparam logic [1:0] MODE_ASR = 2'b01;
   localparam logic [1:0] MODE_LSL = 2'b10;

   logic stall;

   // A result that cannot leave freezes the whole pipe; ready is combinational from out_ready.
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      localparam int unsigned AMT = 32'd1 << k;
      localparam int unsigned ROT = AMT % WIDTH;

      logic [WIDTH-1:0]   src_data;
      logic [SHAMT_W-1:0] src_shamt;
      logic [1:0]         src_mode;
      logic               src_valid;
      logic [WIDTH-1:0]   lsr_data;
      logic [WIDTH-1:0]   asr_data;
      logic [WIDTH-1:0]   lsl_data;
      logic [WIDTH-1:0]   ror_data;
      logic [WIDTH-1:0]   data_d;
      logic [WIDTH-1:0]   data_q;
      logic [SHAMT_W-1:0] shamt_d;
      logic [SHAMT_W-1:0] shamt_q;
      logic [1:0]         mode_d;
      logic [1:0]         mode_q;
      logic               valid_d;
      logic               valid_q;
`ifdef BSH_STICKY_EN
      logic               src_sticky;
      logic               drop_or;
      logic               sticky_d;
      logic               sticky_q;
`endif

      if (k == 0) begin : g_src
         assign src_data   = in_data;
         assign src_shamt  = in_shamt;
         assign src_mode   = in_mode;
         assign src_valid  = in_valid;
`ifdef BSH_STICKY_EN
         assign src_sticky = 1'b0;
`endif
      end else begin : g_src
         assign src_data   = g_stage[k-1].data_q;
         assign src_shamt  = g_stage[k-1].shamt_q;
         assign src_mode   = g_stage[k-1].mode_q;
         assign src_valid  = g_stage[k-1].valid_q;
`ifdef BSH_STICKY_EN
         assign src_sticky = g_stage[k-1].sticky_q;
`endif
      end

      // A stage step as wide as the word drops everything (WIDTH need not be a power of 2).
      if (AMT >= WIDTH) begin : g_drop
         assign lsr_data = '0;
         assign asr_data = {WIDTH{src_data[WIDTH-1]}};
         assign lsl_data = '0;
`ifdef BSH_STICKY_EN
         assign drop_or  = |src_data;
`endif
      end else begin : g_part
         assign lsr_data = src_data >> AMT;
         assign asr_data = (src_data >> AMT) | ({WIDTH{src_data[WIDTH-1]}} << (WIDTH - AMT));
         assign lsl_data = src_data << AMT;
`ifdef BSH_STICKY_EN
         assign drop_or  = |(src_data << (WIDTH - AMT));
`endif
      end

      if (ROT == 0) begin : g_rot_none
         assign ror_data = src_data;
      end else begin : g_rot
         assign ror_data = (src_data >> ROT) | (src_data << (WIDTH - ROT));
      end

      always_comb begin
         data_d   = src_data;
         shamt_d  = src_shamt;
         mode_d   = src_mode;
         valid_d  = src_valid;
`ifdef BSH_STICKY_EN
         sticky_d = src_sticky;
`endif
         if (src_shamt[k]) begin
            case (src_mode)
               MODE_LSR: data_d = lsr_data;
               MODE_ASR: data_d = asr_data;
               MODE_LSL: data_d = lsl_data;
               default:  data_d = ror_data;
            endcase
`ifdef BSH_STICKY_EN
            if ((src_mode == MODE_LSR) || (src_mode == MODE_ASR)) begin
               sticky_d = src_sticky | drop_or;
            end
`endif
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_q   <= '0;
            shamt_q  <= '0;
            mode_q   <= '0;
            valid_q  <= 1'b0;
`ifdef BSH_STICKY_EN
            sticky_q <= 1'b0;
`endif
         end else if (!stall) begin
            data_q   <= data_d;
            shamt_q  <= shamt_d;
            mode_q   <= mode_d;
            valid_q  <= valid_d;
`ifdef BSH_STICKY_EN
            sticky_q <= sticky_d;
`endif
         end
      end
   end

   assign out_valid = g_stage[SHAMT_W-1].valid_q;
   assign out_data  = g_stage[SHAMT_W-1].data_q;
`ifdef BSH_STICKY_EN
   assign out_sticky = g_stage[SHAMT_W-1].sticky_q;
`else
   assign out_sticky = 1'b0;
`endif

   // Shift amount and mode are fully consumed by the time they reach the last register.
   logic unused_tail;
   assign unused_tail = ^{g_stage[SHAMT_W-1].shamt_q, g_stage[SHAMT_W-1].mode_q};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed self-checking bench for pipelined_barrel_shifter (WIDTH=11, SHAMT_W=4).
module tb_pipelined_barrel_shifter;
   localparam int unsigned WIDTH   = 11;
   localparam int unsigned SHAMT_W = 4;
`ifdef BSH_STICKY_EN
   localparam bit STICKY_ON = 1'b1;
`else
   localparam bit STICKY_ON = 1'b0;
`endif
   localparam logic [1:0] LSR = 2'b00;
   localparam logic [1:0] ASR = 2'b01;
   localparam logic [1:0] LSL = 2'b10;
   localparam logic [1:0] ROR = 2'b11;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHAMT_W-1:0] in_shamt;
   logic [1:0]         in_mode;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_sticky;

   int n_cmp = 0;
   int n_err = 0;

   // LSR of 11'h7FF by 0..7
   logic [WIDTH-1:0] s_exp [8] = '{11'h7FF, 11'h3FF, 11'h1FF, 11'h0FF,
                                   11'h07F, 11'h03F, 11'h01F, 11'h00F};

   always #5 clk = ~clk;

   pipelined_barrel_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_shamt(in_shamt), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sticky(out_sticky)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Send one beat from posedge+1 and check latency, data and sticky.
   task automatic run_beat(input string tag, input logic [1:0] mode, input logic [WIDTH-1:0] data,
                           input logic [SHAMT_W-1:0] shamt, input logic [WIDTH-1:0] exp_d,
                           input logic exp_s);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_mode  = mode;
      in_data  = data;
      in_shamt = shamt;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 1; i < int'(SHAMT_W); i++) begin
         chk({tag, " early out_valid"}, 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end
      chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " out_data"}, 32'(out_data), 32'(exp_d));
      chk({tag, " out_sticky"}, 32'(out_sticky), 32'(exp_s & STICKY_ON));
      @(posedge clk); #1;
   endtask

   initial begin
      int tx;
      int rx;
      int last_emit;
      int seen;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_mode   = LSR;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data", 32'(out_data), 32'd0);
      chk("reset out_sticky", 32'(out_sticky), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post-reset in_ready", 32'(in_ready), 32'd1);

      run_beat("lsr 7ff>>3",   LSR, 11'h7FF, 4'd3,  11'h0FF, 1'b1);
      run_beat("asr 400>>2",   ASR, 11'h400, 4'd2,  11'h700, 1'b0);
      run_beat("asr 400>>15",  ASR, 11'h400, 4'd15, 11'h7FF, 1'b1);
      run_beat("lsl 001<<10",  LSL, 11'h001, 4'd10, 11'h400, 1'b0);
      run_beat("lsl 001<<11",  LSL, 11'h001, 4'd11, 11'h000, 1'b0);
      run_beat("ror 001 by12", ROR, 11'h001, 4'd12, 11'h400, 1'b0);
      run_beat("ror 001 by11", ROR, 11'h001, 4'd11, 11'h001, 1'b0);
      run_beat("ror 123 by4",  ROR, 11'h123, 4'd4,  11'h192, 1'b0);
      run_beat("lsr 5a5>>0",   LSR, 11'h5A5, 4'd0,  11'h5A5, 1'b0);
      run_beat("lsr 400>>11",  LSR, 11'h400, 4'd11, 11'h000, 1'b1);
      run_beat("asr 3ff>>4",   ASR, 11'h3FF, 4'd4,  11'h03F, 1'b1);
      run_beat("lsr 010>>4",   LSR, 11'h010, 4'd4,  11'h001, 1'b0);
      run_beat("lsr 008>>4",   LSR, 11'h008, 4'd4,  11'h000, 1'b1);

      // Streaming: 8 beats back-to-back with out_ready low in cycles 6..8.
      tx = 0;
      rx = 0;
      last_emit = -1;
      for (int c = 0; c < 24; c++) begin
         out_ready = !(c >= 6 && c <= 8);
         in_valid  = (tx < 8);
         in_mode   = LSR;
         in_data   = 11'h7FF;
         in_shamt  = SHAMT_W'(tx);
         #1;
         if (c >= 6 && c <= 8) begin
            chk("stall in_ready", 32'(in_ready), 32'd0);
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall out_data hold", 32'(out_data), 32'(s_exp[rx]));
            chk("stall out_sticky hold", 32'(out_sticky), 32'(STICKY_ON && (rx > 0)));
         end
         if (out_valid && out_ready) begin
            if (rx < 8) begin
               chk("stream out_data", 32'(out_data), 32'(s_exp[rx]));
               chk("stream out_sticky", 32'(out_sticky), 32'(STICKY_ON && (rx > 0)));
            end else begin
               chk("stream extra beat", 32'(out_valid), 32'd0);
            end
            rx++;
            last_emit = c;
         end
         if (in_valid && in_ready) tx++;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream beats sent", 32'(tx), 32'd8);
      chk("stream beats received", 32'(rx), 32'd8);
      chk("stream last emit cycle", 32'(last_emit), 32'd14);

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_mode  = LSL;
         in_data  = 11'h001;
         in_shamt = SHAMT_W'(i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre-reset out_valid", 32'(out_valid), 32'd1);
      chk("pre-reset out_data", 32'(out_data), 32'h001);
      rst = 1'b1;
      #1;
      chk("mid reset out_valid", 32'(out_valid), 32'd0);
      chk("mid reset out_data", 32'(out_data), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("stale beats after reset", 32'(seen), 32'd0);
      run_beat("post-reset ror", ROR, 11'h123, 4'd4, 11'h192, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
